// File: rtl/lap_stash.sv
// Circular store of DEPTH WIDTH-bit samples with browsing over valid entries.
// Optional lap-split output sample_delta is enabled by defining LAP_STASH_DELTA_EN.
module lap_stash #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 5,
    localparam int PTR_BITS = $clog2(DEPTH),
    localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [WIDTH-1:0]    sample_in,
    input  logic                sample_in_valid,
    input  logic                next_sample,
    input  logic                prev_sample,
    output logic [WIDTH-1:0]    sample_out,
    output logic [PTR_BITS-1:0] sel_pos,
    output logic [CNT_BITS-1:0] count,
    output logic                empty,
    output logic                full
`ifdef LAP_STASH_DELTA_EN
    ,
    output logic [WIDTH-1:0]    sample_delta
`endif
);

    // Requests are single-cycle pulses with no ready: every cycle a request
    // is high it is acted on once, subject to reset > clear > write > browse.

    logic [WIDTH-1:0]    storage [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] sel;
    logic [PTR_BITS-1:0] oldest;
    logic [PTR_BITS-1:0] newest;
    logic [PTR_BITS-1:0] count_mod;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        if (p == PTR_BITS'(DEPTH - 1)) return '0;
        else return p + PTR_BITS'(1);
    endfunction

    function automatic logic [PTR_BITS-1:0] ptr_dec(input logic [PTR_BITS-1:0] p);
        if (p == '0) return PTR_BITS'(DEPTH - 1);
        else return p - PTR_BITS'(1);
    endfunction

    // Intermediate a+DEPTH may wrap in PTR_BITS, but the final result is < DEPTH.
    function automatic logic [PTR_BITS-1:0] ptr_sub(input logic [PTR_BITS-1:0] a,
                                                     input logic [PTR_BITS-1:0] b);
        if (a >= b) return a - b;
        else return a + PTR_BITS'(DEPTH) - b;
    endfunction

    assign count_mod = (count == CNT_BITS'(DEPTH)) ? '0 : PTR_BITS'(count);
    assign oldest    = ptr_sub(wr_ptr, count_mod);
    assign newest    = ptr_dec(wr_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            sel    <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            sel    <= '0;
            count  <= '0;
        end else if (sample_in_valid) begin
            storage[wr_ptr] <= sample_in;
            sel             <= wr_ptr;
            wr_ptr          <= ptr_inc(wr_ptr);
            if (count != CNT_BITS'(DEPTH)) count <= count + CNT_BITS'(1);
        end else if (count != '0) begin
            // With one entry oldest==newest==sel, so both wraps leave sel put.
            if (next_sample && !prev_sample) begin
                sel <= (sel == newest) ? oldest : ptr_inc(sel);
            end else if (prev_sample && !next_sample) begin
                sel <= (sel == oldest) ? newest : ptr_dec(sel);
            end
        end
    end

    assign empty      = (count == '0);
    assign full       = (count == CNT_BITS'(DEPTH));
    assign sample_out = empty ? '0 : storage[sel];
    assign sel_pos    = empty ? '0 : ptr_sub(sel, oldest);

`ifdef LAP_STASH_DELTA_EN
    assign sample_delta = (empty || sel_pos == '0) ? '0
                        : storage[sel] - storage[ptr_dec(sel)];
`endif

endmodule

// File: tb/tb_lap_stash.sv
// Directed, table-driven bench for lap_stash (DEPTH=4, WIDTH=8); also checks
// sample_delta when LAP_STASH_DELTA_EN is defined.
module tb_lap_stash;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam int NVEC     = 29;

    logic                clk;
    logic                reset;
    logic                clear;
    logic [WIDTH-1:0]    sample_in;
    logic                sample_in_valid;
    logic                next_sample;
    logic                prev_sample;
    logic [WIDTH-1:0]    sample_out;
    logic [PTR_BITS-1:0] sel_pos;
    logic [CNT_BITS-1:0] count;
    logic                empty;
    logic                full;
    logic [WIDTH-1:0]    sample_delta;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic                clr;
        logic                wr;
        logic [WIDTH-1:0]    data;
        logic                nxt;
        logic                prv;
        logic [WIDTH-1:0]    e_out;
        logic [PTR_BITS-1:0] e_pos;
        logic [CNT_BITS-1:0] e_cnt;
        logic [WIDTH-1:0]    e_delta;
    } vec_t;

    vec_t vecs [NVEC];

    lap_stash #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .next_sample     (next_sample),
        .prev_sample     (prev_sample),
        .sample_out      (sample_out),
        .sel_pos         (sel_pos),
        .count           (count),
        .empty           (empty),
        .full            (full)
`ifdef LAP_STASH_DELTA_EN
        ,
        .sample_delta    (sample_delta)
`endif
    );

`ifndef LAP_STASH_DELTA_EN
    assign sample_delta = '0;
`endif

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic clr, input logic wr, input logic [7:0] data,
                                input logic nxt, input logic prv, input logic [7:0] e_out,
                                input int e_pos, input int e_cnt, input logic [7:0] e_delta);
        vec_t v;
        v.clr = clr; v.wr = wr; v.data = data; v.nxt = nxt; v.prv = prv;
        v.e_out = e_out; v.e_pos = PTR_BITS'(e_pos); v.e_cnt = CNT_BITS'(e_cnt);
        v.e_delta = e_delta;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] e_out, input int e_pos,
                               input int e_cnt, input logic [7:0] e_delta);
        check({tag, " sample_out"}, 32'(sample_out), 32'(e_out));
        check({tag, " sel_pos"},    32'(sel_pos),    32'(e_pos));
        check({tag, " count"},      32'(count),      32'(e_cnt));
        check({tag, " empty"},      32'(empty),      32'(e_cnt == 0));
        check({tag, " full"},       32'(full),       32'(e_cnt == DEPTH));
`ifdef LAP_STASH_DELTA_EN
        check({tag, " sample_delta"}, 32'(sample_delta), 32'(e_delta));
`endif
    endtask

    // Driver: hold inputs for one edge, then sample outputs 1 time unit later.
    task automatic drive(input logic rst, input logic clr, input logic wr,
                         input logic [7:0] data, input logic nxt, input logic prv);
        reset = rst; clear = clr; sample_in_valid = wr; sample_in = data;
        next_sample = nxt; prev_sample = prv;
        @(posedge clk);
        #1;
        reset = 1'b0; clear = 1'b0; sample_in_valid = 1'b0; sample_in = '0;
        next_sample = 1'b0; prev_sample = 1'b0;
    endtask

    initial begin
        //            clr wr data   nx pv  out    pos cnt delta
        vecs[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00); // after reset
        vecs[1]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00); // browse while empty
        vecs[2]  = mk(0, 1, 8'h11, 0, 0, 8'h11, 0, 1, 8'h00);
        vecs[3]  = mk(0, 1, 8'h22, 0, 0, 8'h22, 1, 2, 8'h11);
        vecs[4]  = mk(0, 1, 8'h33, 0, 0, 8'h33, 2, 3, 8'h11);
        vecs[5]  = mk(0, 0, 8'h00, 1, 0, 8'h11, 0, 3, 8'h00); // next wraps to oldest
        vecs[6]  = mk(0, 0, 8'h00, 0, 1, 8'h33, 2, 3, 8'h11); // prev wraps to newest
        vecs[7]  = mk(0, 0, 8'h00, 1, 1, 8'h33, 2, 3, 8'h11); // both: no move
        vecs[8]  = mk(0, 1, 8'h44, 0, 0, 8'h44, 3, 4, 8'h11);
        vecs[9]  = mk(0, 1, 8'h55, 0, 0, 8'h55, 3, 4, 8'h11); // overwrites 0x11
        vecs[10] = mk(0, 0, 8'h00, 1, 0, 8'h22, 0, 4, 8'h00);
        vecs[11] = mk(0, 0, 8'h00, 0, 1, 8'h55, 3, 4, 8'h11);
        vecs[12] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00); // clear
        vecs[13] = mk(0, 1, 8'h11, 0, 0, 8'h11, 0, 1, 8'h00);
        vecs[14] = mk(0, 1, 8'h22, 0, 0, 8'h22, 1, 2, 8'h11);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 8'h11, 0, 2, 8'h00);
        vecs[16] = mk(0, 1, 8'h66, 1, 0, 8'h66, 2, 3, 8'h44); // write beats browse
        vecs[17] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
        vecs[18] = mk(0, 1, 8'h77, 0, 0, 8'h77, 0, 1, 8'h00);
        vecs[19] = mk(0, 0, 8'h00, 1, 0, 8'h77, 0, 1, 8'h00); // single entry
        vecs[20] = mk(0, 0, 8'h00, 0, 1, 8'h77, 0, 1, 8'h00);
        vecs[21] = mk(1, 1, 8'h99, 0, 0, 8'h00, 0, 0, 8'h00); // clear beats write
        vecs[22] = mk(0, 1, 8'h10, 0, 0, 8'h10, 0, 1, 8'h00);
        vecs[23] = mk(0, 1, 8'h25, 0, 0, 8'h25, 1, 2, 8'h15);
        vecs[24] = mk(0, 1, 8'h40, 0, 0, 8'h40, 2, 3, 8'h1B);
        vecs[25] = mk(0, 0, 8'h00, 0, 1, 8'h25, 1, 3, 8'h15);
        vecs[26] = mk(0, 0, 8'h00, 0, 1, 8'h10, 0, 3, 8'h00);
        vecs[27] = mk(0, 1, 8'hFE, 0, 0, 8'hFE, 3, 4, 8'hBE);
        vecs[28] = mk(0, 1, 8'h05, 0, 0, 8'h05, 3, 4, 8'h07); // delta wraps mod 256

        reset = 1'b1; clear = 1'b0; sample_in_valid = 1'b0; sample_in = '0;
        next_sample = 1'b0; prev_sample = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("reset", 8'h00, 0, 0, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            drive(1'b0, vecs[i].clr, vecs[i].wr, vecs[i].data, vecs[i].nxt, vecs[i].prv);
            check_state($sformatf("vec%0d", i), vecs[i].e_out, int'(vecs[i].e_pos),
                        int'(vecs[i].e_cnt), vecs[i].e_delta);
        end

        // Full store: next from newest walks oldest..newest in age order.
        exp_q.push_back(8'h25);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h05);
        for (int k = 0; k < DEPTH; k++) begin
            logic [WIDTH-1:0] e;
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            e = exp_q.pop_front();
            check($sformatf("walk%0d sample_out", k), 32'(sample_out), 32'(e));
            check($sformatf("walk%0d sel_pos", k), 32'(sel_pos), 32'(k));
        end

        // Reset wins over a same-cycle write.
        drive(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        check_state("rst_write", 8'h00, 0, 0, 8'h00);

        // Reset wins over a same-cycle browse; storage is zeroed.
        drive(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_state("rst_browse", 8'h00, 0, 0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_state("post_rst_browse", 8'h00, 0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
